// File: rtl/stoch_queue_engine.sv
// stoch_queue_engine: clocked single-instance FIFO/LIFO stochastic queue returning q_* status codes.
// Optional macro STOCH_Q_WAIT_STATS_EN adds per-entry timestamps and shortest/longest wait statistics.
module stoch_queue_engine #(
    parameter int ITEM_W = 32,
    parameter int WGT_W  = 32,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_valid,
    input  logic [1:0]        init_type,
    input  logic [CNT_W-1:0]  init_len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [ITEM_W-1:0] item_in,
    input  logic [WGT_W-1:0]  wgt_in,
    input  logic [2:0]        stat_code,
    output logic              rsp_valid,
    output logic [3:0]        rsp_status,
    output logic [ITEM_W-1:0] rsp_item,
    output logic [WGT_W-1:0]  rsp_wgt,
    output logic [TS_W-1:0]   rsp_value,
    output logic              q_full,
    output logic [CNT_W-1:0]  q_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [3:0] ST_OK = 4'd1, ST_FULL = 4'd2, ST_UNDEF = 4'd3, ST_EMPTY = 4'd4,
                           ST_TYPE = 4'd5, ST_LEN = 4'd6, ST_MEM = 4'd8, ST_CODE = 4'd9;

    logic [ITEM_W-1:0] r_mem_item [DEPTH];
    logic [WGT_W-1:0]  r_mem_wgt  [DEPTH];
    logic              r_inited, r_lifo, r_op_prev;
    logic [CNT_W-1:0]  r_max_len, r_count, r_hi_water;
    logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
    logic [TS_W-1:0]   r_ts;
    logic              r_rsp_valid;
    logic [3:0]        r_rsp_status;
    logic [ITEM_W-1:0] r_rsp_item;
    logic [WGT_W-1:0]  r_rsp_wgt;
    logic [TS_W-1:0]   r_rsp_value;

    logic              w_op_acc, w_rsp, w_push, w_pop, w_init_ok;
    logic [3:0]        w_status;
    logic [ITEM_W-1:0] w_item;
    logic [WGT_W-1:0]  w_wgt;
    logic [TS_W-1:0]   w_value;
    logic [PTR_W-1:0]  w_pop_idx;
    logic [CNT_W-1:0]  w_count_inc;

`ifdef STOCH_Q_WAIT_STATS_EN
    logic [TS_W-1:0]   r_mem_ts [DEPTH];
    logic [TS_W-1:0]   r_min_wait, r_max_wait;
    logic              r_any_rm;
    logic [TS_W-1:0]   w_wait;
    assign w_wait = r_ts - r_mem_ts[w_pop_idx];
`endif

    assign op_ready    = r_inited && !init_valid;
    assign w_op_acc    = op_valid && op_ready;
    assign q_full      = r_inited && (r_count == r_max_len);
    assign q_count     = r_count;
    assign w_count_inc = r_count + CNT_W'(1);
    // LIFO pops the most recent write, FIFO the oldest entry
    assign w_pop_idx   = r_lifo ? (r_wr_ptr - PTR_W'(1)) : r_rd_ptr;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_status = r_rsp_status;
    assign rsp_item   = r_rsp_item;
    assign rsp_wgt    = r_rsp_wgt;
    assign rsp_value  = r_rsp_value;

    always_comb begin
        w_rsp     = 1'b0;
        w_status  = '0;
        w_item    = '0;
        w_wgt     = '0;
        w_value   = '0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_init_ok = 1'b0;
        if (init_valid) begin
            w_rsp = 1'b1;
            if (init_type != 2'd1 && init_type != 2'd2) begin
                w_status = ST_TYPE;
            end else if (init_len == '0) begin
                w_status = ST_LEN;
            end else if (init_len > CNT_W'(DEPTH)) begin
                w_status = ST_MEM;
            end else begin
                w_status  = ST_OK;
                w_init_ok = 1'b1;
            end
        end else if (w_op_acc) begin
            w_rsp    = 1'b1;
            w_status = ST_OK;
            case (op_code)
                2'd0: begin
                    if (r_count == r_max_len) w_status = ST_FULL;
                    else                      w_push   = 1'b1;
                end
                2'd1: begin
                    if (r_count == '0) begin
                        w_status = ST_EMPTY;
                    end else begin
                        w_pop  = 1'b1;
                        w_item = r_mem_item[w_pop_idx];
                        w_wgt  = r_mem_wgt[w_pop_idx];
                    end
                end
                2'd2: begin
                    case (stat_code)
                        3'd1:    w_value = TS_W'(r_count);
                        3'd3:    w_value = TS_W'(r_hi_water);
`ifdef STOCH_Q_WAIT_STATS_EN
                        3'd4:    w_value = r_min_wait;
                        3'd5:    w_value = r_max_wait;
`endif
                        default: w_status = ST_CODE;
                    endcase
                end
                default: w_status = ST_CODE;
            endcase
        end else if (op_valid && !r_op_prev && !r_inited) begin
            // One-shot "undefined queue" answer on a rising request before any INIT
            w_rsp    = 1'b1;
            w_status = ST_UNDEF;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem_item[r_wr_ptr] <= item_in;
            r_mem_wgt[r_wr_ptr]  <= wgt_in;
`ifdef STOCH_Q_WAIT_STATS_EN
            r_mem_ts[r_wr_ptr]   <= r_ts;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inited     <= 1'b0;
            r_lifo       <= 1'b0;
            r_op_prev    <= 1'b0;
            r_max_len    <= '0;
            r_count      <= '0;
            r_hi_water   <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_ts         <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= '0;
            r_rsp_item   <= '0;
            r_rsp_wgt    <= '0;
            r_rsp_value  <= '0;
`ifdef STOCH_Q_WAIT_STATS_EN
            r_min_wait   <= '0;
            r_max_wait   <= '0;
            r_any_rm     <= 1'b0;
`endif
        end else begin
            r_ts         <= r_ts + TS_W'(1);
            r_op_prev    <= op_valid;
            r_rsp_valid  <= w_rsp;
            r_rsp_status <= w_status;
            r_rsp_item   <= w_item;
            r_rsp_wgt    <= w_wgt;
            r_rsp_value  <= w_value;
            if (w_init_ok) begin
                r_inited   <= 1'b1;
                r_lifo     <= (init_type == 2'd2);
                r_max_len  <= init_len;
                r_count    <= '0;
                r_hi_water <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
`ifdef STOCH_Q_WAIT_STATS_EN
                r_min_wait <= '0;
                r_max_wait <= '0;
                r_any_rm   <= 1'b0;
`endif
            end else if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_count  <= w_count_inc;
                if (w_count_inc > r_hi_water) r_hi_water <= w_count_inc;
            end else if (w_pop) begin
                if (r_lifo) r_wr_ptr <= r_wr_ptr - PTR_W'(1);
                else        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= r_count - CNT_W'(1);
`ifdef STOCH_Q_WAIT_STATS_EN
                r_any_rm <= 1'b1;
                if (!r_any_rm || w_wait < r_min_wait) r_min_wait <= w_wait;
                if (!r_any_rm || w_wait > r_max_wait) r_max_wait <= w_wait;
`endif
            end
        end
    end
endmodule

// File: tb/tb_stoch_queue_engine.sv
// Directed table-driven bench for stoch_queue_engine (default DEPTH=8), plus hand sequences
// for wait statistics, reset during an ADD and pointer wrap-around.
module tb_stoch_queue_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        init_valid;
    logic [1:0]  init_type;
    logic [3:0]  init_len;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic [31:0] item_in;
    logic [31:0] wgt_in;
    logic [2:0]  stat_code;
    logic        rsp_valid;
    logic [3:0]  rsp_status;
    logic [31:0] rsp_item;
    logic [31:0] rsp_wgt;
    logic [15:0] rsp_value;
    logic        q_full;
    logic [3:0]  q_count;

    int n_chk  = 0;
    int n_fail = 0;

    stoch_queue_engine dut (
        .clk(clk), .rst(rst), .init_valid(init_valid), .init_type(init_type),
        .init_len(init_len), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .item_in(item_in), .wgt_in(wgt_in), .stat_code(stat_code), .rsp_valid(rsp_valid),
        .rsp_status(rsp_status), .rsp_item(rsp_item), .rsp_wgt(rsp_wgt),
        .rsp_value(rsp_value), .q_full(q_full), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [1:0]  ity;
        logic [3:0]  ilen;
        logic        ov;
        logic [1:0]  oc;
        logic [31:0] item;
        logic [2:0]  stat;
        logic        ev;
        logic [3:0]  est;
        logic [31:0] eitem;
        logic [15:0] eval;
        logic [3:0]  ecnt;
        logic        efull;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [1:0] ity, logic [3:0] ilen, logic ov,
                                logic [1:0] oc, logic [31:0] item, logic [2:0] stat,
                                logic ev, logic [3:0] est, logic [31:0] eitem,
                                logic [15:0] eval, logic [3:0] ecnt, logic efull);
        vec_t v;
        v.iv = iv; v.ity = ity; v.ilen = ilen; v.ov = ov; v.oc = oc; v.item = item;
        v.stat = stat; v.ev = ev; v.est = est; v.eitem = eitem; v.eval = eval;
        v.ecnt = ecnt; v.efull = efull;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Weight stimulus is always item+0x100, so a popped item implies its weight
    task automatic chk_rsp(input string name, input logic [3:0] est, input logic [31:0] eitem,
                           input logic [15:0] eval);
        chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, " status"}, 32'(rsp_status), 32'(est));
        chk({name, " item"}, rsp_item, eitem);
        chk({name, " wgt"}, rsp_wgt, (eitem == 0) ? 32'd0 : eitem + 32'h100);
        chk({name, " value"}, 32'(rsp_value), 32'(eval));
    endtask

    task automatic drive(input logic iv, input logic [1:0] ity, input logic [3:0] ilen,
                         input logic ov, input logic [1:0] oc, input logic [31:0] item,
                         input logic [2:0] stat);
        @(negedge clk);
        rst = 1'b0; init_valid = iv; init_type = ity; init_len = ilen;
        op_valid = ov; op_code = oc; item_in = item; wgt_in = item + 32'h100; stat_code = stat;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] prev;
        rst = 1'b1; init_valid = 0; init_type = 0; init_len = 0; op_valid = 0;
        op_code = 0; item_in = 0; wgt_in = 0; stat_code = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset rsp_status", 32'(rsp_status), 0);
        chk("reset q_count", 32'(q_count), 0);
        chk("reset q_full", 32'(q_full), 0);
        chk("reset op_ready", 32'(op_ready), 0);

        //            iv ity len ov oc item     st  ev est eitem    eval cnt full
        tbl.push_back(mk(0, 0, 0, 1, 0, 32'h9,  0,  1, 3, 0,      0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 32'h9,  0,  0, 0, 0,      0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0,  0, 0, 0,      0,   0, 0));
        tbl.push_back(mk(1, 1, 4, 0, 0, 0,      0,  1, 1, 0,      0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 32'hA,  0,  1, 1, 0,      0,   1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 32'hB,  0,  1, 1, 0,      0,   2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 32'hC,  0,  1, 1, 0,      0,   3, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 32'hD,  0,  1, 1, 0,      0,   4, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 32'hE,  0,  1, 2, 0,      0,   4, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0,      0,  1, 1, 32'hA,  0,   3, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0,      0,  1, 1, 32'hB,  0,   2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0,      0,  1, 1, 32'hC,  0,   1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0,      0,  1, 1, 32'hD,  0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0,      0,  1, 4, 0,      0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0,      3,  1, 1, 0,      4,   0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0,      1,  1, 1, 0,      0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 0,      0,  1, 9, 0,      0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0,      2,  1, 9, 0,      0,   0, 0));
        tbl.push_back(mk(1, 2, 3, 0, 0, 0,      0,  1, 1, 0,      0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 32'h1,  0,  1, 1, 0,      0,   1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 32'h2,  0,  1, 1, 0,      0,   2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 32'h3,  0,  1, 1, 0,      0,   3, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0,      0,  1, 1, 32'h3,  0,   2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0,      0,  1, 1, 32'h2,  0,   1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0,      0,  1, 1, 32'h1,  0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0,      3,  1, 1, 0,      3,   0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 32'h55, 0,  1, 1, 0,      0,   1, 0));
        tbl.push_back(mk(1, 3, 4, 0, 0, 0,      0,  1, 5, 0,      0,   1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,      0,  1, 6, 0,      0,   1, 0));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0,      0,  1, 8, 0,      0,   1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0,      0,  1, 1, 32'h55, 0,   0, 0));
        tbl.push_back(mk(1, 1, 8, 1, 0, 32'h66, 0,  1, 1, 0,      0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0,      0,  1, 4, 0,      0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0,      1,  1, 1, 0,      0,   0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].ity, tbl[i].ilen, tbl[i].ov, tbl[i].oc, tbl[i].item,
                  tbl[i].stat);
            if (tbl[i].ev) chk_rsp($sformatf("v%0d", i), tbl[i].est, tbl[i].eitem, tbl[i].eval);
            else chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 0);
            chk($sformatf("v%0d q_count", i), 32'(q_count), 32'(tbl[i].ecnt));
            chk($sformatf("v%0d q_full", i), 32'(q_full), 32'(tbl[i].efull));
        end

        // Wait-time statistics: waits of 5 and 9 cycles
        drive(1, 1, 4, 0, 0, 0, 0);
        chk_rsp("st init", 1, 0, 0);
        drive(0, 0, 0, 1, 2, 0, 4);
`ifdef STOCH_Q_WAIT_STATS_EN
        chk_rsp("st exam4 none", 1, 0, 0);
`else
        chk_rsp("st exam4 none", 9, 0, 0);
`endif
        drive(0, 0, 0, 1, 0, 32'h11, 0);
        idle(4);
        drive(0, 0, 0, 1, 1, 0, 0);
        chk_rsp("st rm1", 1, 32'h11, 0);
        drive(0, 0, 0, 1, 0, 32'h22, 0);
        idle(8);
        drive(0, 0, 0, 1, 1, 0, 0);
        chk_rsp("st rm2", 1, 32'h22, 0);
        drive(0, 0, 0, 1, 2, 0, 4);
`ifdef STOCH_Q_WAIT_STATS_EN
        chk_rsp("st exam4", 1, 0, 5);
`else
        chk_rsp("st exam4", 9, 0, 0);
`endif
        drive(0, 0, 0, 1, 2, 0, 5);
`ifdef STOCH_Q_WAIT_STATS_EN
        chk_rsp("st exam5", 1, 0, 9);
`else
        chk_rsp("st exam5", 9, 0, 0);
`endif

        // Reset asserted in the same cycle as an ADD
        drive(1, 1, 8, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 32'h31, 0);
        drive(0, 0, 0, 1, 0, 32'h32, 0);
        chk("pre-rst q_count", 32'(q_count), 2);
        @(negedge clk);
        rst = 1'b1; op_valid = 1'b1; op_code = 2'd0; item_in = 32'h33;
        @(posedge clk);
        #1;
        chk("rst-add rsp_valid", 32'(rsp_valid), 0);
        chk("rst-add q_count", 32'(q_count), 0);
        idle(1);
        chk("post-rst rsp_valid", 32'(rsp_valid), 0);
        chk("post-rst op_ready", 32'(op_ready), 0);

        // Pointer wrap: one entry kept in flight over 3*DEPTH add/remove pairs
        drive(1, 1, 8, 0, 0, 0, 0);
        chk_rsp("wr init", 1, 0, 0);
        drive(0, 0, 0, 1, 0, 32'd1000, 0);
        prev = 32'd1000;
        for (int i = 0; i < 24; i++) begin
            drive(0, 0, 0, 1, 0, 32'd2000 + 32'(i), 0);
            chk($sformatf("wr add%0d status", i), 32'(rsp_status), 1);
            drive(0, 0, 0, 1, 1, 0, 0);
            chk_rsp($sformatf("wr rm%0d", i), 1, prev, 0);
            prev = 32'd2000 + 32'(i);
        end
        chk("wr q_count", 32'(q_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
